// File: rtl/seg7_scan_if.sv
// Bus between the datapath and the multiplexed 7-segment scan driver.
// The master side supplies the BCD word and display controls, and the
// slave side (the driver) returns the board-level display signals.
interface seg7_scan_if #(
   parameter int NUM_DIGITS = 4
);
   logic                      load;
   logic [4*NUM_DIGITS-1:0]   digits_in;
   logic [NUM_DIGITS-1:0]     dp_in;
   logic                      lz_blank;
   logic [6:0]                seg;
   logic                      dp;
   logic [NUM_DIGITS-1:0]     an;
   logic                      frame_done;

   modport master (
      output load, digits_in, dp_in, lz_blank,
      input  seg, dp, an, frame_done
   );

   modport slave (
      input  load, digits_in, dp_in, lz_blank,
      output seg, dp, an, frame_done
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// It captures a packed BCD word on load, then lights one digit at a time.
// Each digit is lit for REFRESH_DIV cycles. The driver supports optional
// leading-zero blanking and a decimal point per digit.
module seg7_scan_driver #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   seg7_scan_if.slave bus
);
   localparam int DIV_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = ($clog2(NUM_DIGITS) < 1) ? 1 : $clog2(NUM_DIGITS);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   // Inactive (dark) output levels for the selected polarity
   localparam logic [6:0]            SEG_OFF = {7{ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};
   localparam logic                  DP_OFF  = ACTIVE_LOW;

   // BCD to active-high segments {a..g}; codes 10..15 are not digits and stay dark
   function automatic logic [6:0] bcd_decode(input logic [3:0] code);
      case (code)
         4'd0:    bcd_decode = 7'b1111110;
         4'd1:    bcd_decode = 7'b0110000;
         4'd2:    bcd_decode = 7'b1101101;
         4'd3:    bcd_decode = 7'b1111001;
         4'd4:    bcd_decode = 7'b0110011;
         4'd5:    bcd_decode = 7'b1011011;
         4'd6:    bcd_decode = 7'b1011111;
         4'd7:    bcd_decode = 7'b1110000;
         4'd8:    bcd_decode = 7'b1111111;
         4'd9:    bcd_decode = 7'b1111011;
         default: bcd_decode = 7'b0000000;
      endcase
   endfunction

   logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
   logic [NUM_DIGITS-1:0]   dp_hold_q, dp_hold_d;
   logic [DIV_W-1:0]        div_q, div_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    frame_done_q, frame_done_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_out_q, dp_out_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;

   logic [NUM_DIGITS-1:0]   blank;
   logic                    lead_zero;
   logic [3:0]              cur_digit;
   logic [6:0]              seg_ah;
   logic [NUM_DIGITS-1:0]   an_ah;

   // Capture, refresh divider and digit index next-state logic
   always_comb begin
      // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
      digits_d     = bus.load ? bus.digits_in : digits_q;
      dp_hold_d    = bus.load ? bus.dp_in     : dp_hold_q;
      div_d        = div_q + DIV_W'(1);
      idx_d        = idx_q;
      frame_done_d = 1'b0;
      if (div_q == DIV_LAST) begin
         div_d = '0;
         if (idx_q == IDX_LAST) begin
            idx_d        = '0;
            frame_done_d = 1'b1;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end
   end

   // Leading-zero mask, decode and polarity for the digit selected by idx_q
   always_comb begin
      lead_zero = 1'b1;
      blank     = '0;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         lead_zero = lead_zero & (digits_q[4*k +: 4] == 4'd0);
         blank[k]  = lead_zero;
      end
      cur_digit = digits_q[4*int'(idx_q) +: 4];
      seg_ah    = (bus.lz_blank && blank[idx_q]) ? 7'b0000000 : bcd_decode(cur_digit);
      an_ah        = '0;
      an_ah[idx_q] = 1'b1;
      seg_d    = seg_ah ^ SEG_OFF;
      an_d     = an_ah ^ AN_OFF;
      dp_out_d = dp_hold_q[idx_q] ^ DP_OFF;
   end

   // State and output registers with synchronous reset to a dark display
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the held digit/dp registers are reset too, so a reset mid-scan restarts showing 0 rather than stale data.
         digits_q     <= '0;
         dp_hold_q    <= '0;
         div_q        <= '0;
         idx_q        <= '0;
         frame_done_q <= 1'b0;
         seg_q        <= SEG_OFF;
         an_q         <= AN_OFF;
         dp_out_q     <= DP_OFF;
      end else begin
         // NOTE: non-blocking assignments make every register sample pre-edge values, matching real flops.
         digits_q     <= digits_d;
         dp_hold_q    <= dp_hold_d;
         div_q        <= div_d;
         idx_q        <= idx_d;
         frame_done_q <= frame_done_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
         dp_out_q     <= dp_out_d;
      end
   end

   assign bus.seg        = seg_q;
   assign bus.an         = an_q;
   assign bus.dp         = dp_out_q;
   assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, 4-cycle dwell).
// It drives two instances from the same stimulus: one active-low and one
// active-high. The stimulus queues hand-derived active-high expectations
// tagged with a cycle number. A negedge monitor pops each expectation and
// compares both instances.
module tb_seg7_scan_driver;
   localparam int ND = 4;
   localparam int RD = 4;

   localparam logic [6:0] ZERO = 7'b1111110;
   localparam logic [6:0] DARK = 7'b0000000;
   localparam logic [6:0] DEC_TAB [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
      7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011,
      7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};

   typedef struct {
      int         c;
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fd;
      string      name;
   } exp_t;

   logic clk = 1'b0;
   logic rst, load, lz;
   logic [15:0] digits;
   logic [3:0]  dpv;

   int cyc = 0;
   int base = 0;
   int n_checks = 0;
   int n_err = 0;
   exp_t sb_q[$];

   seg7_scan_if #(.NUM_DIGITS(ND)) if_al();
   seg7_scan_if #(.NUM_DIGITS(ND)) if_ah();

   assign if_al.load = load;   assign if_al.digits_in = digits;
   assign if_al.dp_in = dpv;   assign if_al.lz_blank = lz;
   assign if_ah.load = load;   assign if_ah.digits_in = digits;
   assign if_ah.dp_in = dpv;   assign if_ah.lz_blank = lz;

   seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .ACTIVE_LOW(1'b1)) dut_al (
      .clk (clk),
      .rst (rst),
      .bus (if_al.slave)
   );

   seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .ACTIVE_LOW(1'b0)) dut_ah (
      .clk (clk),
      .rst (rst),
      .bus (if_ah.slave)
   );

   always #5 clk = ~clk;

   // Cycle counter: cyc is the number of rising edges seen so far
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got {an,seg,dp,fd}=%b expected %b", name, act, exp);
      end
   endtask

   // Monitor: compare every queued expectation in the cycle it is due
   always @(negedge clk) begin
      exp_t e;
      while (sb_q.size() > 0 && sb_q[0].c <= cyc) begin
         e = sb_q.pop_front();
         if (e.c < cyc) begin
            n_checks++;
            n_err++;
            $display("FAIL %s@%0d: expectation missed, monitor at cycle %0d", e.name, e.c, cyc);
         end else begin
            check($sformatf("%s@%0d al", e.name, e.c),
                  {if_al.an, if_al.seg, if_al.dp, if_al.frame_done},
                  {~e.an, ~e.seg, ~e.dp, e.fd});
            check($sformatf("%s@%0d ah", e.name, e.c),
                  {if_ah.an, if_ah.seg, if_ah.dp, if_ah.frame_done},
                  {e.an, e.seg, e.dp, e.fd});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input int c, input logic [3:0] an, input logic [6:0] seg,
                           input logic dp, input logic fd, input string name);
      exp_t e;
      e.c = c; e.an = an; e.seg = seg; e.dp = dp; e.fd = fd; e.name = name;
      sb_q.push_back(e);
   endtask

   // Expected scan: digit d lit during cycles base+4d+1..base+4d+4 of each frame,
   // and frame_done high every 16th cycle after the scan restarted
   task automatic push_frame(input int first, input int count, input logic [27:0] segs,
                             input logic [3:0] dps, input string name);
      for (int i = 0; i < count; i++) begin
         int c;
         int d;
         c = cyc + first + i;
         d = ((c - base - 1) / 4) % 4;
         push_one(c, 4'(1 << d), segs[7*d +: 7], dps[d],
                  (c > base) && (((c - base) % 16) == 0), name);
      end
   endtask

   // Change inputs for one edge and expect one full frame of the new picture.
   // A load becomes visible one cycle later than an lz_blank change.
   task automatic apply(input bit do_load, input logic [15:0] dg, input logic [3:0] dp_i,
                        input bit new_lz, input logic [27:0] segs, input logic [3:0] dps,
                        input string name);
      if (do_load) begin
         load   = 1'b1;
         digits = dg;
         dpv    = dp_i;
      end
      lz = new_lz;
      step();
      load = 1'b0;
      push_frame(do_load ? 1 : 0, 16, segs, dps, name);
      repeat (16) step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; load = 1'b0; lz = 1'b0; digits = 16'h0000; dpv = 4'b0000;

      // Reset held for two cycles, then a blank-data scan with one frame_done
      step();
      push_one(cyc, 4'b0000, DARK, 1'b0, 1'b0, "reset");
      step();
      push_one(cyc, 4'b0000, DARK, 1'b0, 1'b0, "reset");
      rst  = 1'b0;
      base = cyc;
      push_frame(1, 17, {ZERO, ZERO, ZERO, ZERO}, 4'b0000, "scan");
      repeat (17) step();

      // 1234 with a decimal point on digit 2
      apply(1'b1, 16'h1234, 4'b0100, 1'b0,
            {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}, 4'b0100, "load1234");

      // Every code in digit 0, including the illegal ones
      for (int v = 0; v < 16; v++) begin
         apply(1'b1, {12'h000, 4'(v)}, 4'b0000, 1'b0,
               {ZERO, ZERO, ZERO, DEC_TAB[v]}, 4'b0000, $sformatf("decode%0d", v));
      end

      // Leading-zero blanking (held word is 000F on entry)
      apply(1'b0, 16'h0000, 4'b0000, 1'b1, {DARK, DARK, DARK, DARK}, 4'b0000, "lz_000F");
      apply(1'b1, 16'h0050, 4'b0000, 1'b1, {DARK, DARK, 7'b1011011, ZERO}, 4'b0000, "lz_0050");
      apply(1'b1, 16'h0A00, 4'b0000, 1'b1, {DARK, DARK, ZERO, ZERO}, 4'b0000, "lz_0A00");
      apply(1'b1, 16'h0000, 4'b0000, 1'b1, {DARK, DARK, DARK, ZERO}, 4'b0000, "lz_0000");
      apply(1'b0, 16'h0000, 4'b0000, 1'b0, {ZERO, ZERO, ZERO, ZERO}, 4'b0000, "lz_off");

      // Load on the same edge the divider wraps
      for (int i = 0; i < 8 && ((cyc - base) % 4) != 3; i++) step();
      apply(1'b1, 16'h9999, 4'b1111, 1'b0,
            {7'b1111011, 7'b1111011, 7'b1111011, 7'b1111011}, 4'b1111, "load_wrap");

      // Reset while digit 2 is lit; held data must be cleared
      for (int i = 0; i < 20 && (((cyc - base - 1) / 4) % 4) != 2; i++) step();
      push_one(cyc, 4'b0100, 7'b1111011, 1'b1, 1'b0, "pre_rst");
      rst = 1'b1;
      step();
      rst = 1'b0;
      push_one(cyc, 4'b0000, DARK, 1'b0, 1'b0, "rst_mid");
      base = cyc;
      push_frame(1, 17, {ZERO, ZERO, ZERO, ZERO}, 4'b0000, "resume");
      repeat (17) step();

      for (int i = 0; i < 50 && sb_q.size() > 0; i++) step();
      if (sb_q.size() > 0) begin
         n_checks++;
         n_err++;
         $display("FAIL drain: %0d expectations never checked, expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
